// File: rtl/input_cmd_manager.sv
// Turns debounced button levels into one-cycle game command pulses.
// Rotate and drop fire once per press; left/right/down add delayed auto-shift paced by tick_game.
module input_cmd_manager #(
  parameter int DAS_DELAY = 16,
  parameter int DAS_SPEED = 4,
  parameter int CNT_W     = $clog2(DAS_DELAY + DAS_SPEED + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_down,
  input  logic raw_rotate,
  input  logic raw_drop,
  output logic cmd_left,
  output logic cmd_right,
  output logic cmd_down,
  output logic cmd_rotate,
  output logic cmd_drop
);

  localparam int NUM_BTN = 5;
  localparam int NUM_DAS = 3;
  localparam logic [CNT_W-1:0] RPT_AT   = CNT_W'(DAS_DELAY + DAS_SPEED);
  localparam logic [CNT_W-1:0] RPT_BACK = CNT_W'(DAS_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bit order: 0 left, 1 right, 2 down, 3 rotate, 4 drop
  logic [NUM_BTN-1:0] raw_s;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] prev_q, prev_d;
  logic [NUM_BTN-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0]   cnt_q [NUM_DAS];
  logic [CNT_W-1:0]   cnt_d [NUM_DAS];

  assign raw_s  = {raw_drop, raw_rotate, raw_down, raw_right, raw_left};
  assign rise_s = raw_s & ~prev_q;

  // Next-state: edge detection for all buttons plus the DAS counters
  always_comb begin
    prev_d = raw_s;
    cmd_d  = {NUM_BTN{1'b0}};
    cmd_d[3] = rise_s[3];
    cmd_d[4] = rise_s[4];
    for (int i = 0; i < NUM_DAS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!raw_s[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (rise_s[i]) begin
        // A fresh press wins over a coincident frame tick
        cmd_d[i] = 1'b1;
        cnt_d[i] = CNT_ZERO;
      end else if (tick_game) begin
        if (cnt_q[i] == RPT_AT) begin
          cmd_d[i] = 1'b1;
          cnt_d[i] = RPT_BACK;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= {NUM_BTN{1'b0}};
      cmd_q  <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_DAS; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      prev_q <= prev_d;
      cmd_q  <= cmd_d;
      for (int i = 0; i < NUM_DAS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cmd_left   = cmd_q[0];
  assign cmd_right  = cmd_q[1];
  assign cmd_down   = cmd_q[2];
  assign cmd_rotate = cmd_q[3];
  assign cmd_drop   = cmd_q[4];

endmodule

// File: tb/tb_input_cmd_manager.sv
// Scoreboard bench for input_cmd_manager: stimulus queues the expected command
// vector per clock, a monitor pops and compares it after each rising edge.
module tb_input_cmd_manager;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] L    = 5'b00001;
  localparam logic [4:0] R    = 5'b00010;
  localparam logic [4:0] D    = 5'b00100;
  localparam logic [4:0] ROT  = 5'b01000;
  localparam logic [4:0] DRP  = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_game = 1'b0;
  logic raw_left = 1'b0, raw_right = 1'b0, raw_down = 1'b0, raw_rotate = 1'b0, raw_drop = 1'b0;
  logic cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop;

  logic [4:0] exp_q [$];
  string      name_q [$];
  int checks = 0;
  int errors = 0;

  input_cmd_manager #(.DAS_DELAY(16), .DAS_SPEED(4)) dut (
    .clk(clk), .rst(rst), .tick_game(tick_game),
    .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
    .raw_rotate(raw_rotate), .raw_drop(raw_drop),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
    .cmd_rotate(cmd_rotate), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  // Drive one clock of inputs and queue the command vector expected after that edge
  task automatic step(input logic [4:0] btn, input logic tk, input logic rstn,
                      input logic [4:0] exp, input string nm);
    @(negedge clk);
    raw_left   = btn[0];
    raw_right  = btn[1];
    raw_down   = btn[2];
    raw_rotate = btn[3];
    raw_drop   = btn[4];
    tick_game  = tk;
    rst        = rstn;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor: compare outputs against the scoreboard just after each edge
  initial begin
    logic [4:0] e;
    logic [4:0] got;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        got = {cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got cmd=%b expected cmd=%b (drop,rot,down,right,left)", n, got, e);
        end
      end
    end
  end

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step(NONE, 1'b0, 1'b0, NONE, "reset");

    // Rotate one-shot, ticks have no effect while held
    step(ROT, 1'b0, 1'b1, ROT, "rot_press");
    for (int i = 0; i < 10; i++) step(ROT, i[0], 1'b1, NONE, "rot_hold");
    step(NONE, 1'b0, 1'b1, NONE, "rot_release");
    step(ROT, 1'b1, 1'b1, ROT, "rot_repress");
    step(ROT, 1'b0, 1'b1, NONE, "rot_repress_hold");
    step(NONE, 1'b0, 1'b1, NONE, "rot_idle");

    // Drop one-shot
    step(DRP, 1'b0, 1'b1, DRP, "drop_press");
    for (int i = 0; i < 10; i++) step(DRP, i[0], 1'b1, NONE, "drop_hold");
    step(NONE, 1'b0, 1'b1, NONE, "drop_release");
    step(DRP, 1'b0, 1'b1, DRP, "drop_repress");
    step(NONE, 1'b0, 1'b1, NONE, "drop_idle");

    // Left DAS: repeats on ticks 21, 25, 29 only
    step(L, 1'b0, 1'b1, L, "left_press");
    for (int t = 1; t <= 30; t++) begin
      step(L, 1'b1, 1'b1, (t == 21 || t == 25 || t == 29) ? L : NONE, "left_das_tick");
      step(L, 1'b0, 1'b1, NONE, "left_das_gap");
    end
    step(NONE, 1'b0, 1'b1, NONE, "left_release");

    // Right: release during delay restarts the timing
    step(R, 1'b0, 1'b1, R, "right_press");
    for (int t = 1; t <= 10; t++) begin
      step(R, 1'b1, 1'b1, NONE, "right_delay_tick");
      step(R, 1'b0, 1'b1, NONE, "right_delay_gap");
    end
    step(NONE, 1'b1, 1'b1, NONE, "right_release");
    step(R, 1'b0, 1'b1, R, "right_repress");
    for (int t = 1; t <= 21; t++) begin
      step(R, 1'b1, 1'b1, (t == 21) ? R : NONE, "right_restart_tick");
      step(R, 1'b0, 1'b1, NONE, "right_restart_gap");
    end
    step(NONE, 1'b0, 1'b1, NONE, "right_idle");

    // Down: press coinciding with a tick gives one pulse and counts from zero
    step(D, 1'b1, 1'b1, D, "down_press_tick");
    for (int t = 1; t <= 21; t++) begin
      step(D, 1'b1, 1'b1, (t == 21) ? D : NONE, "down_das_tick");
      step(D, 1'b0, 1'b1, NONE, "down_das_gap");
    end
    step(NONE, 1'b0, 1'b1, NONE, "down_idle");

    // Reset mid-hold, then a still-held button re-triggers its initial move
    step(L, 1'b0, 1'b1, L, "rst_left_press");
    for (int t = 1; t <= 23; t++) begin
      step(L, 1'b1, 1'b1, (t == 21) ? L : NONE, "rst_left_tick");
      step(L, 1'b0, 1'b1, NONE, "rst_left_gap");
    end
    step(L, 1'b1, 1'b0, NONE, "rst_hold_low");
    step(L, 1'b1, 1'b0, NONE, "rst_hold_low");
    step(L, 1'b0, 1'b1, L, "rst_release_rise");
    for (int t = 1; t <= 21; t++) begin
      step(L, 1'b1, 1'b1, (t == 21) ? L : NONE, "rst_after_tick");
    end
    step(NONE, 1'b0, 1'b1, NONE, "rst_left_release");

    // Left and right held together are independent; rotate mid-hold pulses alone
    step(L | R, 1'b0, 1'b1, L | R, "both_press");
    for (int t = 1; t <= 21; t++) begin
      step(L | R, 1'b1, 1'b1, (t == 21) ? (L | R) : NONE, "both_tick");
      step((t == 10) ? (L | R | ROT) : (L | R), 1'b0, 1'b1,
           (t == 10) ? ROT : NONE, "both_gap_rot");
    end
    step(NONE, 1'b0, 1'b1, NONE, "both_release");
    step(NONE, 1'b0, 1'b1, NONE, "final_idle");

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
